// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (I) and data load/store (D).
// Define ARB_ROUND_ROBIN_EN to alternate the winner on simultaneous requests; default is fixed D priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              PORT_SEL
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              i_req;
  logic              d_req;
  logic              in_acc;
  logic              done;
  logic              grant_pt;
  logic              i_cand;
  logic              d_cand;
  logic              d_win;
  logic              i_win;
  logic              cmd_wr;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  assign i_req    = I_READ;
  assign d_req    = D_READ | D_WRITE;
  assign in_acc   = (state != IDLE);
  assign done     = in_acc && !MEM_BUSYWAIT;
  assign grant_pt = !in_acc || done;

  // The requester finishing this cycle may not win the very next access.
  assign i_cand = i_req && !(done && state == I_ACC);
  assign d_cand = d_req && !(done && state == D_ACC);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  assign d_win = grant_pt && d_cand && (!i_cand || !last_d);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_d <= 1'b0;
    end else if (d_win || i_win) begin
      last_d <= d_win;
    end
  end
`else
  assign d_win = grant_pt && d_cand;
`endif

  assign i_win = grant_pt && i_cand && !d_win;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (d_win) begin
      state_nxt = D_ACC;
    end else if (i_win) begin
      state_nxt = I_ACC;
    end else if (grant_pt) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    MEM_READ   = in_acc && !cmd_wr;
    MEM_WRITE  = in_acc && cmd_wr;
    I_BUSYWAIT = i_req && !(state == I_ACC && done);
    D_BUSYWAIT = d_req && !(state == D_ACC && done);
    I_READDATA = (state == I_ACC && done) ? MEM_READDATA : i_rdata_q;
    D_READDATA = (state == D_ACC && done) ? MEM_READDATA : d_rdata_q;
  end

  // Command, address and store data are frozen at the grant edge for the whole access.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cmd_wr  <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (d_win) begin
      cmd_wr  <= D_WRITE;
      sel_q   <= 1'b1;
      addr_q  <= D_ADDRESS;
      wdata_q <= D_WRITEDATA;
    end else if (i_win) begin
      cmd_wr  <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= I_ADDRESS;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (done) begin
      if (state == I_ACC) begin
        i_rdata_q <= MEM_READDATA;
      end else begin
        d_rdata_q <= MEM_READDATA;
      end
    end
  end

  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;
  assign PORT_SEL      = sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random requester agents scored against a transaction model.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_READ;
  logic [31:0] I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ;
  logic        D_WRITE;
  logic [31:0] D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic        PORT_SEL;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .PORT_SEL(PORT_SEL)
  );

  always #5 CLK = ~CLK;

  // Memory device: busy for cur_lat cycles of each command, then one completion cycle.
  logic [31:0] tb_mem [0:255];
  logic [31:0] ref_mem [0:255];
  int mcnt = 0;
  int rlat = 1;
  int fixed_lat = 0;
  bit fixed_mode = 1'b1;
  int cur_lat;

  assign cur_lat      = fixed_mode ? fixed_lat : rlat;
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt < cur_lat);
  assign MEM_READDATA = tb_mem[MEM_ADDRESS[9:2]];

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        mcnt <= 0;
        rlat <= $urandom_range(0, 3);
        if (MEM_WRITE) tb_mem[MEM_ADDRESS[9:2]] <= MEM_WRITEDATA;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h100 + ({28'd0, 4'($urandom_range(0, 15))} << 2);
    return a;
  endfunction

  // Transaction-level model state for the random phase.
  bit          m_gp, m_icand, m_dcand, m_dwr;
  logic [31:0] m_iaddr, m_daddr, m_dwdata;
  bit          in_acc, owner_d, acc_wr, last_d, comp, ibw, dbw, win_d;
  logic [31:0] acc_addr, acc_wdata;
  int          i_cool, d_cool, op;

  initial begin
    RESET = 1'b0;
    I_READ = 1'b0; I_ADDRESS = '0;
    D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'h5A00_0000 | i;
      ref_mem[i] = 32'h5A00_0000 | i;
    end
    tb_mem[16] = 32'h00A0_0093; ref_mem[16] = 32'h00A0_0093;
    tb_mem[17] = 32'h1234_5678; ref_mem[17] = 32'h1234_5678;

    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_mem_read", MEM_READ, 0);
    check("rst_mem_write", MEM_WRITE, 0);
    check("rst_port_sel", PORT_SEL, 0);
    check("rst_i_bw", I_BUSYWAIT, 0);
    check("rst_d_bw", D_BUSYWAIT, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);

    // Single fetch, 3 busy cycles
    fixed_lat = 3;
    I_READ = 1'b1; I_ADDRESS = 32'h40;
    #1;
    check("fetch_first_bw", I_BUSYWAIT, 1);
    check("fetch_first_noread", MEM_READ, 0);
    @(negedge CLK);
    check("fetch_c1_read", MEM_READ, 1);
    check("fetch_c1_addr", MEM_ADDRESS, 32'h40);
    check("fetch_c1_sel", PORT_SEL, 0);
    check("fetch_c1_bw", I_BUSYWAIT, 1);
    @(negedge CLK);
    @(negedge CLK);
    check("fetch_c3_bw", I_BUSYWAIT, 1);
    check("fetch_c3_read", MEM_READ, 1);
    @(negedge CLK);
    check("fetch_c4_bw", I_BUSYWAIT, 0);
    check("fetch_c4_data", I_READDATA, 32'h00A0_0093);
    I_READ = 1'b0;
    @(negedge CLK);
    check("fetch_idle_read", MEM_READ, 0);
    check("fetch_hold_data", I_READDATA, 32'h00A0_0093);

    // Contention: D write wins, I follows without a bubble
    fixed_lat = 1;
    I_READ = 1'b1; I_ADDRESS = 32'h44;
    D_WRITE = 1'b1; D_ADDRESS = 32'h100; D_WRITEDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("cont_c1_sel", PORT_SEL, 1);
    check("cont_c1_write", MEM_WRITE, 1);
    check("cont_c1_read", MEM_READ, 0);
    check("cont_c1_addr", MEM_ADDRESS, 32'h100);
    check("cont_c1_wdata", MEM_WRITEDATA, 32'hDEAD_BEEF);
    check("cont_c1_dbw", D_BUSYWAIT, 1);
    @(negedge CLK);
    check("cont_c2_dbw", D_BUSYWAIT, 0);
    check("cont_c2_ibw", I_BUSYWAIT, 1);
    D_WRITE = 1'b0;
    ref_mem[64] = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("cont_c3_sel", PORT_SEL, 0);
    check("cont_c3_read", MEM_READ, 1);
    check("cont_c3_addr", MEM_ADDRESS, 32'h44);
    @(negedge CLK);
    check("cont_c4_ibw", I_BUSYWAIT, 0);
    check("cont_c4_data", I_READDATA, 32'h1234_5678);
    I_READ = 1'b0;
    @(negedge CLK);
    check("cont_mem_written", tb_mem[64], 32'hDEAD_BEEF);
    check("cont_idle", MEM_READ, 0);

    // Both held with zero-wait memory: grants alternate D, I, D, I
    fixed_lat = 0;
    I_READ = 1'b1; I_ADDRESS = 32'h40;
    D_READ = 1'b1; D_ADDRESS = 32'h44;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("alt_sel%0d", k), PORT_SEL, (k % 2 == 0) ? 1 : 0);
      check($sformatf("alt_read%0d", k), MEM_READ, 1);
      if (k % 2 == 0) check($sformatf("alt_ddata%0d", k), D_READDATA, 32'h1234_5678);
      else            check($sformatf("alt_idata%0d", k), I_READDATA, 32'h00A0_0093);
    end
    I_READ = 1'b0; D_READ = 1'b0;
    @(negedge CLK);
    check("alt_idle", MEM_READ, 0);

    // Flush: D read dropped in the second busy cycle still completes
    fixed_lat = 3;
    D_READ = 1'b1; D_ADDRESS = 32'h100;
    @(negedge CLK);
    check("flush_c1_read", MEM_READ, 1);
    check("flush_c1_addr", MEM_ADDRESS, 32'h100);
    @(negedge CLK);
    check("flush_c2_read", MEM_READ, 1);
    D_READ = 1'b0; D_ADDRESS = 32'h1FC;
    @(negedge CLK);
    check("flush_c3_read", MEM_READ, 1);
    check("flush_c3_addr", MEM_ADDRESS, 32'h100);
    check("flush_c3_dbw", D_BUSYWAIT, 0);
    @(negedge CLK);
    check("flush_c4_read", MEM_READ, 1);
    check("flush_c4_addr", MEM_ADDRESS, 32'h100);
    @(negedge CLK);
    check("flush_c5_idle", MEM_READ, 0);

    // Reset during a D write
    D_WRITE = 1'b1; D_ADDRESS = 32'h108; D_WRITEDATA = 32'hCAFE_F00D;
    @(negedge CLK);
    check("rstacc_write", MEM_WRITE, 1);
    #2 RESET = 1'b0;
    #1;
    check("rstacc_write_drop", MEM_WRITE, 0);
    check("rstacc_read_drop", MEM_READ, 0);
    check("rstacc_dbw_held", D_BUSYWAIT, 1);
    check("rstacc_sel", PORT_SEL, 0);
    @(negedge CLK);
    check("rstacc_dbw_still", D_BUSYWAIT, 1);
    D_WRITE = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check("rstacc_idle_write", MEM_WRITE, 0);
    check("rstacc_idle_read", MEM_READ, 0);
    check("rstacc_no_store", tb_mem[66], ref_mem[66]);

    // Random phase against the transaction model
    fixed_mode = 1'b0;
    m_gp = 1'b1; m_icand = 1'b0; m_dcand = 1'b0;
    in_acc = 1'b0; owner_d = 1'b0; acc_wr = 1'b0; last_d = 1'b0;
    acc_addr = '0; acc_wdata = '0;
    i_cool = 0; d_cool = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      if (m_gp) begin
        if (m_icand || m_dcand) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_d = m_dcand && (!m_icand || !last_d);
`else
          win_d = m_dcand;
`endif
          in_acc = 1'b1; owner_d = win_d; last_d = win_d;
          acc_addr  = win_d ? m_daddr : m_iaddr;
          acc_wr    = win_d && m_dwr;
          acc_wdata = m_dwdata;
          check("rnd_grant_cmd", MEM_READ | MEM_WRITE, 1);
          check("rnd_grant_sel", PORT_SEL, win_d);
          check("rnd_grant_addr", MEM_ADDRESS, acc_addr);
          check("rnd_grant_wr", MEM_WRITE, acc_wr);
          if (acc_wr) check("rnd_grant_wdata", MEM_WRITEDATA, acc_wdata);
        end else begin
          in_acc = 1'b0;
          check("rnd_idle_cmd", MEM_READ | MEM_WRITE, 0);
        end
      end else begin
        check("rnd_hold_cmd", MEM_READ | MEM_WRITE, 1);
        check("rnd_hold_addr", MEM_ADDRESS, acc_addr);
        check("rnd_hold_sel", PORT_SEL, owner_d);
        check("rnd_hold_wr", MEM_WRITE, acc_wr);
      end

      comp = in_acc && !MEM_BUSYWAIT;
      check("rnd_ibw", I_BUSYWAIT, I_READ && !(comp && !owner_d));
      check("rnd_dbw", D_BUSYWAIT, (D_READ | D_WRITE) && !(comp && owner_d));
      if (comp) begin
        if (!owner_d && I_READ) check("rnd_idata", I_READDATA, ref_mem[acc_addr[9:2]]);
        if (owner_d && !acc_wr && D_READ && !D_WRITE)
          check("rnd_ddata", D_READDATA, ref_mem[acc_addr[9:2]]);
        if (acc_wr) ref_mem[acc_addr[9:2]] = acc_wdata;
      end
      ibw = I_BUSYWAIT;
      dbw = D_BUSYWAIT;

      // Requester agents: hold until released, occasionally flush, cool down after a flush
      if (i_cool > 0) i_cool--;
      if (I_READ) begin
        if (!ibw) begin
          I_READ = ($urandom_range(0, 1) == 1);
          I_ADDRESS = rand_addr();
        end else if ($urandom_range(0, 31) == 0) begin
          I_READ = 1'b0; i_cool = 6;
        end
      end else if (i_cool == 0 && $urandom_range(0, 2) == 0) begin
        I_READ = 1'b1; I_ADDRESS = rand_addr();
      end

      if (d_cool > 0) d_cool--;
      if (D_READ | D_WRITE) begin
        if (!dbw) begin
          D_READ = 1'b0; D_WRITE = 1'b0;
        end else if ($urandom_range(0, 31) == 0) begin
          D_READ = 1'b0; D_WRITE = 1'b0; d_cool = 6;
        end
      end else if (d_cool == 0 && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 2);
        D_READ  = (op != 1);
        D_WRITE = (op != 0);
        D_ADDRESS = rand_addr();
        D_WRITEDATA = $urandom;
      end

      m_gp     = !in_acc || comp;
      m_icand  = I_READ && !(comp && !owner_d);
      m_dcand  = (D_READ | D_WRITE) && !(comp && owner_d);
      m_iaddr  = I_ADDRESS;
      m_daddr  = D_ADDRESS;
      m_dwr    = D_WRITE;
      m_dwdata = D_WRITEDATA;
      if (comp) in_acc = 1'b0;
    end

    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    repeat (8) @(negedge CLK);
    check("end_idle", MEM_READ | MEM_WRITE, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
